// File: rtl/reg_read_bypass_stage_pkg.sv
// Shared physical-register path types and default widths for the register-read stage.
package BasicTypes;

   localparam int unsigned PREG_NUM_BITS  = 7;
   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned PREG_DATA_BITS = DATA_WIDTH + 1;

   typedef logic [PREG_NUM_BITS-1:0] PRegNumPath;

   // Operand word as carried on every register-file and writeback data path.
   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } PRegDataPath;

endpackage

// File: rtl/reg_read_bypass_stage_operand_select.sv
// Single-operand bypass mux: the lowest-index writeback hitting the source register
// wins over register-file data; register 0 never matches.
module bypass_operand_select
   import BasicTypes::*;
#(
   parameter int unsigned WB_NUM    = 3,
   parameter int unsigned PREG_BITS = PREG_NUM_BITS,
   parameter int unsigned DATA_BITS = DATA_WIDTH
) (
   input  logic [PREG_BITS-1:0]            src_reg_num_i,
   input  logic [DATA_BITS:0]              rf_data_i,
   input  logic [WB_NUM-1:0]               wb_we_i,
   input  logic [WB_NUM*PREG_BITS-1:0]     wb_reg_num_i,
   input  logic [WB_NUM*(DATA_BITS+1)-1:0] wb_data_i,
   output logic [DATA_BITS:0]              sel_data_c_o
);

   localparam int unsigned WORD_BITS = DATA_BITS + 1;

   logic hit;

   // Priority scan from port 0 upward; the first hit locks the selection.
   always_comb begin
      sel_data_c_o = rf_data_i;
      hit          = 1'b0;
      for (int k = 0; k < int'(WB_NUM); k++) begin
         if (!hit && wb_we_i[k] && (src_reg_num_i != '0) &&
             (wb_reg_num_i[k*PREG_BITS +: PREG_BITS] == src_reg_num_i)) begin
            sel_data_c_o = wb_data_i[k*WORD_BITS +: WORD_BITS];
            hit          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_read_bypass_stage.sv
// Register-read stage: bypasses same-cycle writebacks into source operands and registers
// them for execute. Define RSD_REG_READ_STALL_SNOOP_EN to keep held operands current during stall.
module reg_read_bypass_stage
   import BasicTypes::*;
#(
   parameter int unsigned LANE_NUM  = 2,
   parameter int unsigned WB_NUM    = 3,
   parameter int unsigned PREG_BITS = PREG_NUM_BITS,
   parameter int unsigned DATA_BITS = DATA_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              stall,
   input  logic [LANE_NUM-1:0]               inValid,
   input  logic [LANE_NUM*PREG_BITS-1:0]     inSrcRegNumA,
   input  logic [LANE_NUM*PREG_BITS-1:0]     inSrcRegNumB,
   output logic [LANE_NUM*PREG_BITS-1:0]     rfRegNumA,
   output logic [LANE_NUM*PREG_BITS-1:0]     rfRegNumB,
   input  logic [LANE_NUM*(DATA_BITS+1)-1:0] rfDataA,
   input  logic [LANE_NUM*(DATA_BITS+1)-1:0] rfDataB,
   input  logic [WB_NUM-1:0]                 wbWE,
   input  logic [WB_NUM*PREG_BITS-1:0]       wbRegNum,
   input  logic [WB_NUM*(DATA_BITS+1)-1:0]   wbData,
   output logic [LANE_NUM-1:0]               outValid,
   output logic [LANE_NUM*PREG_BITS-1:0]     outSrcRegNumA,
   output logic [LANE_NUM*PREG_BITS-1:0]     outSrcRegNumB,
   output logic [LANE_NUM*(DATA_BITS+1)-1:0] outDataA,
   output logic [LANE_NUM*(DATA_BITS+1)-1:0] outDataB
);

   localparam int unsigned WORD_BITS = DATA_BITS + 1;
   localparam int unsigned REG_W     = LANE_NUM * PREG_BITS;
   localparam int unsigned DAT_W     = LANE_NUM * WORD_BITS;

   logic [LANE_NUM-1:0] valid_q,  valid_d;
   logic [REG_W-1:0]    src_a_q,  src_a_d;
   logic [REG_W-1:0]    src_b_q,  src_b_d;
   logic [DAT_W-1:0]    data_a_q, data_a_d;
   logic [DAT_W-1:0]    data_b_q, data_b_d;
   logic [DAT_W-1:0]    sel_a_c,  sel_b_c;

   assign rfRegNumA = inSrcRegNumA;
   assign rfRegNumB = inSrcRegNumB;

   for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
      bypass_operand_select #(
         .WB_NUM    (WB_NUM),
         .PREG_BITS (PREG_BITS),
         .DATA_BITS (DATA_BITS)
      ) u_sel_a (
         .src_reg_num_i (inSrcRegNumA[l*PREG_BITS +: PREG_BITS]),
         .rf_data_i     (rfDataA[l*WORD_BITS +: WORD_BITS]),
         .wb_we_i       (wbWE),
         .wb_reg_num_i  (wbRegNum),
         .wb_data_i     (wbData),
         .sel_data_c_o  (sel_a_c[l*WORD_BITS +: WORD_BITS])
      );

      bypass_operand_select #(
         .WB_NUM    (WB_NUM),
         .PREG_BITS (PREG_BITS),
         .DATA_BITS (DATA_BITS)
      ) u_sel_b (
         .src_reg_num_i (inSrcRegNumB[l*PREG_BITS +: PREG_BITS]),
         .rf_data_i     (rfDataB[l*WORD_BITS +: WORD_BITS]),
         .wb_we_i       (wbWE),
         .wb_reg_num_i  (wbRegNum),
         .wb_data_i     (wbData),
         .sel_data_c_o  (sel_b_c[l*WORD_BITS +: WORD_BITS])
      );
   end

`ifdef RSD_REG_READ_STALL_SNOOP_EN
   logic [DAT_W-1:0] snp_a_c, snp_b_c;

   // Snoop muxes compare writebacks against the held source numbers, falling back to held data.
   for (genvar l = 0; l < LANE_NUM; l++) begin : g_snoop
      bypass_operand_select #(
         .WB_NUM    (WB_NUM),
         .PREG_BITS (PREG_BITS),
         .DATA_BITS (DATA_BITS)
      ) u_snp_a (
         .src_reg_num_i (src_a_q[l*PREG_BITS +: PREG_BITS]),
         .rf_data_i     (data_a_q[l*WORD_BITS +: WORD_BITS]),
         .wb_we_i       (wbWE),
         .wb_reg_num_i  (wbRegNum),
         .wb_data_i     (wbData),
         .sel_data_c_o  (snp_a_c[l*WORD_BITS +: WORD_BITS])
      );

      bypass_operand_select #(
         .WB_NUM    (WB_NUM),
         .PREG_BITS (PREG_BITS),
         .DATA_BITS (DATA_BITS)
      ) u_snp_b (
         .src_reg_num_i (src_b_q[l*PREG_BITS +: PREG_BITS]),
         .rf_data_i     (data_b_q[l*WORD_BITS +: WORD_BITS]),
         .wb_we_i       (wbWE),
         .wb_reg_num_i  (wbRegNum),
         .wb_data_i     (wbData),
         .sel_data_c_o  (snp_b_c[l*WORD_BITS +: WORD_BITS])
      );
   end
`endif

   // Load on advance, hold on stall; flush only needs to kill the valid bits.
   always_comb begin
      valid_d  = valid_q;
      src_a_d  = src_a_q;
      src_b_d  = src_b_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
      if (!stall) begin
         valid_d  = inValid;
         src_a_d  = inSrcRegNumA;
         src_b_d  = inSrcRegNumB;
         data_a_d = sel_a_c;
         data_b_d = sel_b_c;
      end
`ifdef RSD_REG_READ_STALL_SNOOP_EN
      else begin
         data_a_d = snp_a_c;
         data_b_d = snp_b_c;
      end
`endif
      if (flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
      end else begin
         valid_q  <= valid_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
      end
   end

   assign outValid      = valid_q;
   assign outSrcRegNumA = src_a_q;
   assign outSrcRegNumB = src_b_q;
   assign outDataA      = data_a_q;
   assign outDataB      = data_b_q;

endmodule

// File: tb/tb_reg_read_bypass_stage.sv
// Bench for reg_read_bypass_stage: directed cases plus randomized traffic against a
// queue-based scoreboard fed by an operand-level reference model.
module tb_reg_read_bypass_stage;
   import BasicTypes::*;

   localparam int unsigned LN = 2;
   localparam int unsigned WB = 3;
   localparam int unsigned PB = 7;
   localparam int unsigned DB = 32;
   localparam int unsigned W  = DB + 1;

   logic              clk = 1'b0;
   logic              rst, flush, stall;
   logic [LN-1:0]     inValid;
   logic [LN*PB-1:0]  inSrcRegNumA, inSrcRegNumB, rfRegNumA, rfRegNumB;
   logic [LN*W-1:0]   rfDataA, rfDataB;
   logic [WB-1:0]     wbWE;
   logic [WB*PB-1:0]  wbRegNum;
   logic [WB*W-1:0]   wbData;
   logic [LN-1:0]     outValid;
   logic [LN*PB-1:0]  outSrcRegNumA, outSrcRegNumB;
   logic [LN*W-1:0]   outDataA, outDataB;

   // Per-element stimulus, packed onto the flat DUT buses below.
   logic [PB-1:0] src_a [LN];
   logic [PB-1:0] src_b [LN];
   logic [W-1:0]  rf_a  [LN];
   logic [W-1:0]  rf_b  [LN];
   logic [PB-1:0] wreg  [WB];
   logic [W-1:0]  wdata [WB];

   for (genvar l = 0; l < LN; l++) begin : g_pack_lane
      assign inSrcRegNumA[l*PB +: PB] = src_a[l];
      assign inSrcRegNumB[l*PB +: PB] = src_b[l];
      assign rfDataA[l*W +: W]        = rf_a[l];
      assign rfDataB[l*W +: W]        = rf_b[l];
   end
   for (genvar k = 0; k < WB; k++) begin : g_pack_wb
      assign wbRegNum[k*PB +: PB] = wreg[k];
      assign wbData[k*W +: W]     = wdata[k];
   end

   reg_read_bypass_stage #(
      .LANE_NUM (LN), .WB_NUM (WB), .PREG_BITS (PB), .DATA_BITS (DB)
   ) dut (
      .clk (clk), .rst (rst), .flush (flush), .stall (stall),
      .inValid (inValid), .inSrcRegNumA (inSrcRegNumA), .inSrcRegNumB (inSrcRegNumB),
      .rfRegNumA (rfRegNumA), .rfRegNumB (rfRegNumB),
      .rfDataA (rfDataA), .rfDataB (rfDataB),
      .wbWE (wbWE), .wbRegNum (wbRegNum), .wbData (wbData),
      .outValid (outValid), .outSrcRegNumA (outSrcRegNumA), .outSrcRegNumB (outSrcRegNumB),
      .outDataA (outDataA), .outDataB (outDataB)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LN-1:0]    valid;
      logic [LN*PB-1:0] src_a;
      logic [LN*PB-1:0] src_b;
      logic [LN*W-1:0]  dat_a;
      logic [LN*W-1:0]  dat_b;
   } exp_t;

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   multi_hits = 0;

   // Reference model state: what execute should see after the next edge.
   logic          m_valid [LN];
   logic [PB-1:0] m_src_a [LN];
   logic [PB-1:0] m_src_b [LN];
   logic [W-1:0]  m_dat_a [LN];
   logic [W-1:0]  m_dat_b [LN];

   function automatic logic [W-1:0] pick(input logic [PB-1:0] src, input logic [W-1:0] fallback);
      for (int k = 0; k < int'(WB); k++)
         if (wbWE[k] && src != 0 && wreg[k] == src) return wdata[k];
      return fallback;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      inValid = '0; wbWE = '0; flush = 1'b0; stall = 1'b0;
      for (int l = 0; l < int'(LN); l++) begin
         src_a[l] = '0; src_b[l] = '0; rf_a[l] = '0; rf_b[l] = '0;
      end
      for (int k = 0; k < int'(WB); k++) begin
         wreg[k] = '0; wdata[k] = '0;
      end
   endtask

   // Called at a negedge with inputs applied: predict, push, advance one cycle.
   task automatic step();
      exp_t e;
      #1;
      chk("rf_addr_a", 128'(rfRegNumA), 128'(inSrcRegNumA));
      chk("rf_addr_b", 128'(rfRegNumB), 128'(inSrcRegNumB));
      if (rst) begin
         for (int l = 0; l < int'(LN); l++) begin
            m_valid[l] = 1'b0; m_src_a[l] = '0; m_src_b[l] = '0;
            m_dat_a[l] = '0;   m_dat_b[l] = '0;
         end
      end else begin
         for (int l = 0; l < int'(LN); l++) begin
            if (!stall) begin
               m_valid[l] = inValid[l];
               m_src_a[l] = src_a[l];
               m_src_b[l] = src_b[l];
               m_dat_a[l] = pick(src_a[l], rf_a[l]);
               m_dat_b[l] = pick(src_b[l], rf_b[l]);
            end else begin
`ifdef RSD_REG_READ_STALL_SNOOP_EN
               m_dat_a[l] = pick(m_src_a[l], m_dat_a[l]);
               m_dat_b[l] = pick(m_src_b[l], m_dat_b[l]);
`endif
            end
            if (flush) m_valid[l] = 1'b0;
         end
      end
      for (int l = 0; l < int'(LN); l++) begin
         e.valid[l]          = m_valid[l];
         e.src_a[l*PB +: PB] = m_src_a[l];
         e.src_b[l*PB +: PB] = m_src_b[l];
         e.dat_a[l*W +: W]   = m_dat_a[l];
         e.dat_b[l*W +: W]   = m_dat_b[l];
      end
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: after each edge, compare the presented outputs with the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_valid", 128'(outValid), 128'(e.valid));
            for (int l = 0; l < int'(LN); l++) begin
               if (e.valid[l]) begin
                  chk("sb_src_a",  128'(outSrcRegNumA[l*PB +: PB]), 128'(e.src_a[l*PB +: PB]));
                  chk("sb_src_b",  128'(outSrcRegNumB[l*PB +: PB]), 128'(e.src_b[l*PB +: PB]));
                  chk("sb_data_a", 128'(outDataA[l*W +: W]),        128'(e.dat_a[l*W +: W]));
                  chk("sb_data_b", 128'(outDataB[l*W +: W]),        128'(e.dat_b[l*W +: W]));
               end
            end
         end
      end
   end

   // Flags the illegal case of two writeback ports hitting one issuing source register.
   always @(posedge clk) begin
      if (!rst && !stall) begin
         for (int l = 0; l < int'(LN); l++) begin
            int na, nb;
            na = 0; nb = 0;
            for (int k = 0; k < int'(WB); k++) begin
               if (wbWE[k] && src_a[l] != 0 && wreg[k] == src_a[l]) na++;
               if (wbWE[k] && src_b[l] != 0 && wreg[k] == src_b[l]) nb++;
            end
            if (na > 1 || nb > 1) begin
               multi_hits++;
               $display("note: multiple writeback ports hit one source register on lane %0d", l);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] snoop_exp;
      for (int l = 0; l < int'(LN); l++) begin
         m_valid[l] = 1'b0; m_src_a[l] = '0; m_src_b[l] = '0; m_dat_a[l] = '0; m_dat_b[l] = '0;
      end
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      chk("reset_valid",  128'(outValid),      128'(0));
      chk("reset_data_a", 128'(outDataA),      128'(0));
      chk("reset_data_b", 128'(outDataB),      128'(0));
      chk("reset_src_a",  128'(outSrcRegNumA), 128'(0));
      rst = 1'b0;

      // Plain register-file read.
      clear_inputs();
      inValid = 2'b01; src_a[0] = 7'd5; rf_a[0] = {1'b1, 32'h1234};
      step();
      chk("nobypass_data", 128'(outDataA[W-1:0]), 128'({1'b1, 32'h1234}));
      chk("nobypass_valid", 128'(outValid[0]), 128'(1));

      // Writeback bypass, then the zero register ignoring a writeback to reg 0.
      clear_inputs();
      inValid = 2'b01; src_a[0] = 7'd5; rf_a[0] = {1'b1, 32'h1111};
      wbWE = 3'b010; wreg[1] = 7'd5; wdata[1] = {1'b1, 32'hBEEF};
      step();
      chk("bypass_data", 128'(outDataA[W-1:0]), 128'({1'b1, 32'hBEEF}));
      src_a[0] = 7'd0; wreg[1] = 7'd0;
      step();
      chk("zero_reg_data", 128'(outDataA[W-1:0]), 128'({1'b1, 32'h1111}));

      // Held operand during stall, with a writeback to its register.
      clear_inputs();
      inValid = 2'b01; src_b[0] = 7'd9; rf_b[0] = {1'b1, 32'hAAAA};
      step();
      chk("snoop_capture", 128'(outDataB[W-1:0]), 128'({1'b1, 32'hAAAA}));
      stall = 1'b1; inValid = 2'b00; rf_b[0] = {1'b1, 32'hCCCC};
      wbWE = 3'b001; wreg[0] = 7'd9; wdata[0] = {1'b1, 32'h5555};
      step();
`ifdef RSD_REG_READ_STALL_SNOOP_EN
      snoop_exp = {1'b1, 32'h5555};
`else
      snoop_exp = {1'b1, 32'hAAAA};
`endif
      chk("stall_data_b", 128'(outDataB[W-1:0]), 128'(snoop_exp));
      chk("stall_valid",  128'(outValid[0]), 128'(1));
      chk("stall_src_b",  128'(outSrcRegNumB[PB-1:0]), 128'(9));

      // Flush wins over stall.
      clear_inputs();
      inValid = 2'b11;
      step();
      chk("pre_flush_valid", 128'(outValid), 128'(2'b11));
      stall = 1'b1; flush = 1'b1;
      step();
      chk("flush_over_stall", 128'(outValid), 128'(2'b00));

      // Two ports hitting the same register: lowest index wins and the checker flags it.
      clear_inputs();
      inValid = 2'b01; src_a[0] = 7'd7; rf_a[0] = {1'b1, 32'h0};
      wbWE = 3'b011; wreg[0] = 7'd7; wreg[1] = 7'd7;
      wdata[0] = {1'b1, 32'h77}; wdata[1] = {1'b1, 32'h88};
      step();
      chk("multi_match_data", 128'(outDataA[W-1:0]), 128'({1'b1, 32'h77}));
      chk("multi_match_flag", 128'(multi_hits), 128'(1));

      // Asynchronous reset between edges while stalled with live outputs.
      clear_inputs();
      inValid = 2'b11; src_a[0] = 7'd3; rf_a[0] = {1'b1, 32'h33};
      step();
      chk("pre_reset_valid", 128'(outValid), 128'(2'b11));
      stall = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid",  128'(outValid),      128'(0));
      chk("async_rst_data_a", 128'(outDataA),      128'(0));
      chk("async_rst_src_a",  128'(outSrcRegNumA), 128'(0));
      step();
      rst = 1'b0;
      stall = 1'b0;

      // Randomized traffic; writeback registers drawn from disjoint ranges stay legal.
      for (int i = 0; i < 400; i++) begin
         inValid = LN'($urandom_range(0, 3));
         for (int l = 0; l < int'(LN); l++) begin
            src_a[l] = PB'($urandom_range(0, 15));
            src_b[l] = PB'($urandom_range(0, 15));
            rf_a[l]  = {1'($urandom_range(0, 1)), 32'($urandom)};
            rf_b[l]  = {1'($urandom_range(0, 1)), 32'($urandom)};
         end
         wbWE = WB'($urandom_range(0, 7));
         for (int k = 0; k < int'(WB); k++) begin
            wreg[k]  = PB'(k * 5 + $urandom_range(0, 4));
            wdata[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
         end
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      chk("sb_drained", 128'(sb.size()), 128'(0));
      chk("multi_match_total", 128'(multi_hits), 128'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_read_bypass_stage.md
REG_READ_BYPASS_STAGE -- requirements
Module: reg_read_bypass_stage

Interface
REQ-001 SHALL have parameter LANE_NUM, default 2, number of issue lanes served.
REQ-002 SHALL have parameter WB_NUM, default 3, number of writeback ports (int, complex, load).
REQ-003 SHALL have parameter PREG_BITS, default 7, physical register number width.
REQ-004 SHALL have parameter DATA_BITS, default 32, operand data width; each operand word is {valid, data} = DATA_BITS+1 bits.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  squash all in-flight lanes.
REQ-008 SHALL have port stall  in  1  hold output registers.
REQ-009 SHALL have port inValid  in  LANE_NUM  per-lane issue valid.
REQ-010 SHALL have ports inSrcRegNumA/B  in  LANE_NUM*PREG_BITS  source register numbers.
REQ-011 SHALL have ports rfRegNumA/B  out  LANE_NUM*PREG_BITS  register file read addresses.
REQ-012 SHALL have ports rfDataA/B  in  LANE_NUM*(DATA_BITS+1)  register file combinational read data.
REQ-013 SHALL have ports wbWE  in  WB_NUM, wbRegNum  in  WB_NUM*PREG_BITS, wbData  in  WB_NUM*(DATA_BITS+1)  same-cycle writebacks.
REQ-014 SHALL have ports outValid  out  LANE_NUM, outSrcRegNumA/B  out  LANE_NUM*PREG_BITS, outDataA/B  out  LANE_NUM*(DATA_BITS+1)  registered operands to execute.

Function
REQ-015 rfRegNumA/B SHALL equal inSrcRegNumA/B combinationally, zero latency.
REQ-016 Per operand, selected value SHALL be wbData[k] for the lowest k with wbWE[k] and wbRegNum[k]==srcRegNum, else rfData.
REQ-017 srcRegNum 0 (zero register) SHALL never match a writeback; value always from rfData.
REQ-018 When !stall and !flush: outValid<=inValid, outSrcRegNum<=inSrcRegNum, outData<=selected value; one-cycle latency.
REQ-019 Output data/regnum registers SHALL load regardless of lane valid; only outValid gates use.
REQ-020 When stall and !flush: outValid and outSrcRegNum SHALL hold; inputs ignored (upstream holds them).
REQ-021 flush SHALL clear outValid to 0 on next edge, dominating stall; data registers don't-care.
REQ-022 More than one writeback port matching the same register in one cycle is illegal; bench assertion SHALL flag it; RTL resolves by lowest index.

Reset
REQ-023 rst SHALL asynchronously clear outValid, outSrcRegNumA/B, outDataA/B (including valid bit) to 0.
REQ-024 rst asserted mid-stall or mid-flush SHALL override both; first post-reset edge behaves per REQ-018/020/021.

Configuration
REQ-025 Macro RSD_REG_READ_STALL_SNOOP_EN SHALL gate writeback snooping during stall.
REQ-026 With macro: while stall, each held outData SHALL be replaced by wbData[k] on any matching writeback (REQ-016/017 rules against outSrcRegNum), so operands stay current.
REQ-027 Without macro: outData SHALL hold unchanged during stall; snoop comparators not instantiated.

Structure
REQ-028 PRegNumPath and PRegDataPath {valid,data} typedefs and width constants SHALL live in shared package BasicTypes.
REQ-029 One sub-module bypass_operand_select SHALL implement REQ-016/017 for one operand; instantiated 2*LANE_NUM times (plus 2*LANE_NUM for snoop when enabled).

Verification
REQ-030 No bypass: rfDataA=0x1234 on reg 5, no wbWE -> next cycle outDataA={1,0x1234}, outValid=1.
REQ-031 Bypass: srcA=5, rfDataA=0x1111, wbWE[1]=1 wbRegNum[1]=5 wbData={1,0xBEEF} -> outDataA={1,0xBEEF}; same with srcA=0 -> rfData retained.
REQ-032 Stall snoop: lane0 captured srcB=9 data 0xAAAA, stall=1, then wb reg 9 = 0x5555 -> with macro outDataB=0x5555, without macro 0xAAAA; outValid held 1.
REQ-033 Flush vs stall: outValid=2'b11, stall=1 and flush=1 same cycle -> next edge outValid=2'b00.
REQ-034 Async reset mid-operation: rst pulsed between edges with outValid=1 -> outputs 0 immediately, before next clk edge.
REQ-035 Multi-match: wbWE=3'b011 both to reg 7 -> assertion fires, outData equals wbData[0].
